// File: rtl/max_pool_2x2_if.sv
// max_pool_2x2_if: configuration, input stream and pooled-output bundle
interface max_pool_2x2_if #(parameter int DW = 16);
    logic                 cfg_valid;
    logic [3:0]           cfg_size;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    modport master (
        output cfg_valid, cfg_size, in_valid, in_data,
        input  out_valid, out_data, out_last, busy
    );

    modport slave (
        input  cfg_valid, cfg_size, in_valid, in_data,
        output out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 stride-2 signed max pooling with a half-row line buffer
module max_pool_2x2 #(
    parameter int MAX_SIZE = 12,
    parameter int DW       = 16
) (
    input logic           clk,
    input logic           rst_n,
    max_pool_2x2_if.slave bus
);
    localparam int DEPTH = MAX_SIZE / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]           state;
    logic [3:0]           size, row, col, lim;
    logic [AW-1:0]        idx;
    logic                 cfg_ok, accept, col_end, last_in, win;
    logic signed [DW-1:0] held, pair_max, lb_rd, win_max;
    logic signed [DW-1:0] line_buf [DEPTH];

    // Decode acceptance, window position and the two signed max stages
    always_comb begin
        cfg_ok   = bus.cfg_valid && bus.cfg_size >= 4'd2 && bus.cfg_size <= 4'(MAX_SIZE);
        accept   = state == RUN && bus.in_valid;
        col_end  = col == size - 4'd1;
        last_in  = accept && col_end && row == size - 4'd1;
        lim      = {size[3:1], 1'b0} - 4'd1;
        idx      = AW'(col >> 1);
        pair_max = (held > bus.in_data) ? held : bus.in_data;
        lb_rd    = line_buf[idx];
        win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
        win      = accept && row[0] && col[0];
    end

    // FSM and row/column counters; the frame ends on the S*S-th accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            size  <= '0;
            row   <= '0;
            col   <= '0;
        end else if (state == IDLE) begin
            if (cfg_ok) begin
                state <= RUN;
                size  <= bus.cfg_size;
                row   <= '0;
                col   <= '0;
            end
        end else if (accept) begin
            col   <= col_end ? 4'd0 : col + 4'd1;
            row   <= col_end ? row + 4'd1 : row;
            state <= last_in ? IDLE : RUN;
        end
    end

    // Hold even-column samples and park even-row pair maxima in the line buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
            for (int i = 0; i < DEPTH; i++) line_buf[i] <= '0;
        end else if (accept) begin
            if (!col[0]) held <= bus.in_data;
            else if (!row[0]) line_buf[idx] <= pair_max;
        end
    end

    // Register one pooled result per completed window, flagging the frame's last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            bus.out_valid <= win;
            bus.out_last  <= win && row == lim && col == lim;
            if (win) bus.out_data <= win_max;
        end
    end

    assign bus.busy = state == RUN;
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: directed self-checking bench for the 2x2 max-pooling stage
module tb_max_pool_2x2;
    logic clk, rst_n;
    int passes = 0, total = 0, n_acc = 0;
    logic signed [15:0] got_d[$];
    logic got_l[$];
    int got_n[$];

    max_pool_2x2_if #(.DW(16)) bus ();
    max_pool_2x2 #(.MAX_SIZE(12), .DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every output pulse with the number of inputs accepted before it
    always @(negedge clk) begin
        if (bus.out_valid) begin
            got_d.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
            got_n.push_back(n_acc);
        end
    end

    task automatic clear_q();
        got_d.delete(); got_l.delete(); got_n.delete(); n_acc = 0;
    endtask

    task automatic send(input logic v, input logic signed [15:0] d);
        bus.in_valid = v; bus.in_data = d;
        @(posedge clk);
        if (v) n_acc++;
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic configure(input logic [3:0] s);
        bus.cfg_valid = 1'b1; bus.cfg_size = s;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #2;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passes++;
        total++; if (bus.out_data !== 16'sd0) $display("FAIL reset_out_data got %0d want 0", bus.out_data); else passes++;
        total++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", bus.out_last); else passes++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passes++;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_s4();
        logic signed [15:0] ed[4] = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
        int en[4] = '{6, 8, 14, 16};
        clear_q();
        configure(4'd4);
        total++; if (bus.busy !== 1'b1) $display("FAIL s4_busy_rise got %b want 1", bus.busy); else passes++;
        for (int i = 0; i < 16; i++) send(1'b1, 16'(i));
        total++; if (bus.busy !== 1'b0) $display("FAIL s4_busy_fall got %b want 0", bus.busy); else passes++;
        idle(2);
        total++; if (got_d.size() !== 4) $display("FAIL s4_count got %0d want 4", got_d.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_d.size()) $display("FAIL s4_out%0d missing want data %0d", i, ed[i]);
            else if (got_d[i] !== ed[i] || got_l[i] !== (i == 3) || got_n[i] !== en[i])
                $display("FAIL s4_out%0d got data %0d last %b after %0d want data %0d last %b after %0d",
                         i, got_d[i], got_l[i], got_n[i], ed[i], i == 3, en[i]);
            else passes++;
        end
    endtask

    task automatic test_s5_odd();
        logic signed [15:0] ed[4] = '{16'sd6, 16'sd8, 16'sd16, 16'sd18};
        int en[4] = '{7, 9, 17, 19};
        clear_q();
        configure(4'd5);
        for (int i = 0; i < 24; i++) send(1'b1, 16'(i));
        total++; if (bus.busy !== 1'b1) $display("FAIL s5_busy_before_last got %b want 1", bus.busy); else passes++;
        send(1'b1, 16'sd24);
        total++; if (bus.busy !== 1'b0) $display("FAIL s5_busy_after_last got %b want 0", bus.busy); else passes++;
        idle(2);
        total++; if (got_d.size() !== 4) $display("FAIL s5_count got %0d want 4", got_d.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_d.size()) $display("FAIL s5_out%0d missing want data %0d", i, ed[i]);
            else if (got_d[i] !== ed[i] || got_l[i] !== (i == 3) || got_n[i] !== en[i])
                $display("FAIL s5_out%0d got data %0d last %b after %0d want data %0d last %b after %0d",
                         i, got_d[i], got_l[i], got_n[i], ed[i], i == 3, en[i]);
            else passes++;
        end
    endtask

    task automatic test_negative_back_to_back();
        clear_q();
        configure(4'd2);
        send(1'b1, -16'sd300); send(1'b1, -16'sd5); send(1'b1, -16'sd32768); send(1'b1, -16'sd6);
        configure(4'd2);
        total++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", bus.busy); else passes++;
        send(1'b1, 16'sd32767); send(1'b1, -16'sd1); send(1'b1, 16'sd0); send(1'b1, 16'sd0);
        idle(2);
        total++; if (got_d.size() !== 2) $display("FAIL neg_count got %0d want 2", got_d.size()); else passes++;
        total++;
        if (got_d.size() < 1 || got_d[0] !== -16'sd5 || got_l[0] !== 1'b1)
            $display("FAIL neg_out got %0d last %b want -5 last 1", got_d.size() ? got_d[0] : 16'sd0, got_d.size() ? got_l[0] : 1'b0);
        else passes++;
        total++;
        if (got_d.size() < 2 || got_d[1] !== 16'sd32767 || got_l[1] !== 1'b1)
            $display("FAIL pos_out got %0d want 32767 last 1", got_d.size() > 1 ? got_d[1] : 16'sd0);
        else passes++;
    endtask

    task automatic test_random_gaps();
        logic signed [15:0] img[8][8];
        logic signed [15:0] ew[16];
        logic signed [15:0] a, b, c, d, m;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) img[r][k] = 16'($urandom);
        for (int wr = 0; wr < 4; wr++)
            for (int wc = 0; wc < 4; wc++) begin
                a = img[2*wr][2*wc]; b = img[2*wr][2*wc+1];
                c = img[2*wr+1][2*wc]; d = img[2*wr+1][2*wc+1];
                m = a;
                if (b > m) m = b;
                if (c > m) m = c;
                if (d > m) m = d;
                ew[wr*4+wc] = m;
            end
        clear_q();
        configure(4'd8);
        for (int i = 0; i < 64; i++) begin
            if (i == 30) begin
                bus.cfg_valid = 1'b1; bus.cfg_size = 4'd4;
                send(1'b0, 16'sd0);
                bus.cfg_valid = 1'b0;
                total++; if (bus.busy !== 1'b1) $display("FAIL rnd_cfg_ignored busy got %b want 1", bus.busy); else passes++;
            end
            while ($urandom_range(0, 1) == 1) send(1'b0, 16'sd0);
            send(1'b1, img[i/8][i%8]);
        end
        idle(2);
        total++; if (got_d.size() !== 16) $display("FAIL rnd_count got %0d want 16", got_d.size()); else passes++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= got_d.size()) $display("FAIL rnd_out%0d missing want %0d", i, ew[i]);
            else if (got_d[i] !== ew[i] || got_l[i] !== (i == 15))
                $display("FAIL rnd_out%0d got %0d last %b want %0d last %b", i, got_d[i], got_l[i], ew[i], i == 15);
            else passes++;
        end
    endtask

    task automatic test_bad_cfg();
        logic [3:0] bad[3] = '{4'd0, 4'd1, 4'd13};
        clear_q();
        for (int i = 0; i < 3; i++) begin
            configure(bad[i]);
            total++; if (bus.busy !== 1'b0) $display("FAIL bad_cfg_%0d busy got %b want 0", bad[i], bus.busy); else passes++;
        end
        for (int i = 0; i < 8; i++) send(1'b1, 16'(100 + i));
        idle(2);
        total++; if (got_d.size() !== 0) $display("FAIL idle_inputs outputs got %0d want 0", got_d.size()); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        logic signed [15:0] ed[4] = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
        clear_q();
        configure(4'd6);
        for (int i = 0; i < 20; i++) send(1'b1, 16'(i));
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd19)
            $display("FAIL mid_pre_reset got valid %b data %0d want valid 1 data 19", bus.out_valid, bus.out_data);
        else passes++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); else passes++;
        total++; if (bus.out_data !== 16'sd0) $display("FAIL mid_rst_data got %0d want 0", bus.out_data); else passes++;
        total++; if (bus.out_last !== 1'b0) $display("FAIL mid_rst_last got %b want 0", bus.out_last); else passes++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", bus.busy); else passes++;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_q();
        configure(4'd4);
        for (int i = 0; i < 16; i++) send(1'b1, 16'(i));
        idle(2);
        total++; if (got_d.size() !== 4) $display("FAIL post_rst_count got %0d want 4", got_d.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_d.size()) $display("FAIL post_rst_out%0d missing want %0d", i, ed[i]);
            else if (got_d[i] !== ed[i] || got_l[i] !== (i == 3))
                $display("FAIL post_rst_out%0d got %0d last %b want %0d last %b", i, got_d[i], got_l[i], ed[i], i == 3);
            else passes++;
        end
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_size = 4'd0; bus.in_valid = 1'b0; bus.in_data = 16'sd0;
        test_reset();
        test_s4();
        test_s5_odd();
        test_negative_back_to_back();
        test_random_gaps();
        test_bad_cfg();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
